// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// The fetch stage reads it combinationally; the decode stage writes back resolved branches.
module branch_predictor_btb #(
   parameter int ADDR_WIDTH = 32,
   parameter int ENTRIES    = 16,
   parameter int CTR_BITS   = 2,
   parameter int STAT_WIDTH = 16
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [ADDR_WIDTH-1:0] LookupPC,
   output logic                  PredHit,
   output logic                  PredTaken,
   output logic [ADDR_WIDTH-1:0] PredNextPC,
   input  logic                  UpdValid,
   input  logic [ADDR_WIDTH-1:0] UpdPC,
   input  logic                  UpdTaken,
   input  logic [ADDR_WIDTH-1:0] UpdTarget,
   input  logic                  UpdPredTaken,
   input  logic [ADDR_WIDTH-1:0] UpdPredTarget,
   output logic                  Mispredict,
   output logic [STAT_WIDTH-1:0] BranchCount,
   output logic [STAT_WIDTH-1:0] MispredictCount
);

   localparam int IDX   = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_WIDTH - IDX - 2;

   localparam logic [CTR_BITS-1:0]   CTR_MAX  = {CTR_BITS{1'b1}};
   localparam logic [CTR_BITS-1:0]   CTR_WNT  = CTR_MAX >> 1;
   localparam logic [CTR_BITS-1:0]   CTR_WT   = CTR_MAX ^ (CTR_MAX >> 1);
   localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};

   function automatic logic [CTR_BITS-1:0] ctr_inc(input logic [CTR_BITS-1:0] c);
      return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
   endfunction

   function automatic logic [CTR_BITS-1:0] ctr_dec(input logic [CTR_BITS-1:0] c);
      return (c == {CTR_BITS{1'b0}}) ? c : c - CTR_BITS'(1);
   endfunction

   function automatic logic [STAT_WIDTH-1:0] stat_inc(input logic [STAT_WIDTH-1:0] s);
      return (s == STAT_MAX) ? s : s + STAT_WIDTH'(1);
   endfunction

   logic [ENTRIES-1:0]    valid_q;
   logic [TAG_W-1:0]      tag_q [ENTRIES];
   logic [ADDR_WIDTH-1:0] tgt_q [ENTRIES];
   logic [CTR_BITS-1:0]   ctr_q [ENTRIES];

   logic                  mis_q;
   logic [STAT_WIDTH-1:0] branch_cnt_q;
   logic [STAT_WIDTH-1:0] mis_cnt_q;

   logic [IDX-1:0]        lk_idx_s;
   logic [TAG_W-1:0]      lk_tag_s;
   logic [IDX-1:0]        upd_idx_s;
   logic [TAG_W-1:0]      upd_tag_s;
   logic                  upd_hit_s;
   logic                  upd_we_s;
   logic                  mis_cond_s;
   logic [ADDR_WIDTH-1:0] ent_tgt_d;
   logic [CTR_BITS-1:0]   ent_ctr_d;
   logic                  mis_d;
   logic [STAT_WIDTH-1:0] branch_cnt_d;
   logic [STAT_WIDTH-1:0] mis_cnt_d;
   logic                  unused_s;

   assign lk_idx_s  = LookupPC[IDX+1:2];
   assign lk_tag_s  = LookupPC[ADDR_WIDTH-1:IDX+2];
   assign upd_idx_s = UpdPC[IDX+1:2];
   assign upd_tag_s = UpdPC[ADDR_WIDTH-1:IDX+2];
   assign unused_s  = &{1'b0, LookupPC[1:0], UpdPC[1:0]};

   // Fetch-side lookup: reads the array as it stood before the coming edge.
   always_comb begin
      PredHit    = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
      PredTaken  = PredHit && ctr_q[lk_idx_s][CTR_BITS-1];
      if (PredTaken) begin
         PredNextPC = tgt_q[lk_idx_s];
      end else begin
         PredNextPC = LookupPC + ADDR_WIDTH'(4);
      end
   end

   // Decode-side writeback: compute the new contents of the addressed entry.
   always_comb begin
      upd_hit_s = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);
      upd_we_s  = 1'b0;
      ent_tgt_d = tgt_q[upd_idx_s];
      ent_ctr_d = ctr_q[upd_idx_s];
      if (UpdValid) begin
         if (upd_hit_s) begin
            upd_we_s = 1'b1;
            if (UpdTaken) begin
               ent_ctr_d = ctr_inc(ctr_q[upd_idx_s]);
               ent_tgt_d = UpdTarget;
            end else begin
               ent_ctr_d = ctr_dec(ctr_q[upd_idx_s]);
            end
         end else if (UpdTaken) begin
            // Allocation evicts whatever aliased branch held this slot.
            upd_we_s  = 1'b1;
            ent_ctr_d = CTR_WT;
            ent_tgt_d = UpdTarget;
         end else begin
            upd_we_s = 1'b0;
         end
      end else begin
         upd_we_s = 1'b0;
      end
   end

   // Mispredict flag and saturating statistics next-state.
   always_comb begin
      mis_cond_s   = (UpdPredTaken != UpdTaken) ||
                     (UpdTaken && (UpdPredTarget != UpdTarget));
      mis_d        = 1'b0;
      branch_cnt_d = branch_cnt_q;
      mis_cnt_d    = mis_cnt_q;
      if (UpdValid) begin
         mis_d        = mis_cond_s;
         branch_cnt_d = stat_inc(branch_cnt_q);
         if (mis_cond_s) begin
            mis_cnt_d = stat_inc(mis_cnt_q);
         end else begin
            mis_cnt_d = mis_cnt_q;
         end
      end else begin
         mis_d = 1'b0;
      end
   end

   // Prediction array storage.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         valid_q <= {ENTRIES{1'b0}};
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i] <= {TAG_W{1'b0}};
            tgt_q[i] <= {ADDR_WIDTH{1'b0}};
            ctr_q[i] <= CTR_WNT;
         end
      end else if (upd_we_s) begin
         valid_q[upd_idx_s] <= 1'b1;
         tag_q[upd_idx_s]   <= upd_tag_s;
         tgt_q[upd_idx_s]   <= ent_tgt_d;
         ctr_q[upd_idx_s]   <= ent_ctr_d;
      end else begin
         valid_q <= valid_q;
      end
   end

   // Registered mispredict pulse and statistics.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         mis_q        <= 1'b0;
         branch_cnt_q <= {STAT_WIDTH{1'b0}};
         mis_cnt_q    <= {STAT_WIDTH{1'b0}};
      end else begin
         mis_q        <= mis_d;
         branch_cnt_q <= branch_cnt_d;
         mis_cnt_q    <= mis_cnt_d;
      end
   end

   assign Mispredict      = mis_q;
   assign BranchCount     = branch_cnt_q;
   assign MispredictCount = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: vector table with a scoreboard
// for the registered outputs, plus hand sequences for async reset and stat saturation.
module tb_branch_predictor_btb;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] LookupPC;
   logic        UpdValid, UpdTaken, UpdPredTaken;
   logic [31:0] UpdPC, UpdTarget, UpdPredTarget;

   logic        PredHit, PredTaken, Mispredict;
   logic [31:0] PredNextPC;
   logic [15:0] BranchCount, MispredictCount;

   logic        s_hit, s_taken, s_mis;
   logic [31:0] s_npc;
   logic [1:0]  s_bc, s_mc;

   always #5 Clk = ~Clk;

   branch_predictor_btb u_dut (
      .Clk(Clk), .Reset(Reset), .LookupPC(LookupPC),
      .PredHit(PredHit), .PredTaken(PredTaken), .PredNextPC(PredNextPC),
      .UpdValid(UpdValid), .UpdPC(UpdPC), .UpdTaken(UpdTaken), .UpdTarget(UpdTarget),
      .UpdPredTaken(UpdPredTaken), .UpdPredTarget(UpdPredTarget),
      .Mispredict(Mispredict), .BranchCount(BranchCount), .MispredictCount(MispredictCount)
   );

   branch_predictor_btb #(.STAT_WIDTH(2)) u_dut_sat (
      .Clk(Clk), .Reset(Reset), .LookupPC(LookupPC),
      .PredHit(s_hit), .PredTaken(s_taken), .PredNextPC(s_npc),
      .UpdValid(UpdValid), .UpdPC(UpdPC), .UpdTaken(UpdTaken), .UpdTarget(UpdTarget),
      .UpdPredTaken(UpdPredTaken), .UpdPredTarget(UpdPredTarget),
      .Mispredict(s_mis), .BranchCount(s_bc), .MispredictCount(s_mc)
   );

   typedef struct {
      logic [31:0] lk_pc;
      logic        upd_v;
      logic [31:0] upd_pc;
      logic        upd_tk;
      logic [31:0] upd_tgt;
      logic        upd_ptk;
      logic [31:0] upd_ptgt;
      logic        exp_hit;
      logic        exp_tk;
      logic [31:0] exp_npc;
      logic        exp_mis;
      int          exp_bc;
      int          exp_mc;
   } vec_t;

   typedef struct {
      logic mis;
      int   bc;
      int   mc;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic vec_t mk(input logic [31:0] lk, input logic v, input logic [31:0] pc,
                               input logic tk, input logic [31:0] tgt, input logic ptk,
                               input logic [31:0] ptgt, input logic eh, input logic et,
                               input logic [31:0] en, input logic em, input int eb, input int emc);
      vec_t r;
      r = '{lk, v, pc, tk, tgt, ptk, ptgt, eh, et, en, em, eb, emc};
      return r;
   endfunction

   function automatic int sat3(input int x);
      return (x > 3) ? 3 : x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [31:0] lk, input logic v, input logic [31:0] pc, input logic tk,
                        input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
      LookupPC      = lk;
      UpdValid      = v;
      UpdPC         = pc;
      UpdTaken      = tk;
      UpdTarget     = tgt;
      UpdPredTaken  = ptk;
      UpdPredTarget = ptgt;
   endtask

   task automatic check_lookup(input string nm, input logic h, input logic t, input logic [31:0] n);
      chk({nm, "_hit"}, {31'd0, PredHit}, {31'd0, h});
      chk({nm, "_taken"}, {31'd0, PredTaken}, {31'd0, t});
      chk({nm, "_npc"}, PredNextPC, n);
      chk({nm, "_npc_sat"}, s_npc, n);
   endtask

   task automatic check_regs(input string nm, input sb_t e);
      chk({nm, "_mis"}, {31'd0, Mispredict}, {31'd0, e.mis});
      chk({nm, "_mis_sat"}, {31'd0, s_mis}, {31'd0, e.mis});
      chk({nm, "_bc"}, {16'd0, BranchCount}, 32'(e.bc));
      chk({nm, "_mc"}, {16'd0, MispredictCount}, 32'(e.mc));
      chk({nm, "_bc_sat"}, {30'd0, s_bc}, 32'(sat3(e.bc)));
      chk({nm, "_mc_sat"}, {30'd0, s_mc}, 32'(sat3(e.mc)));
   endtask

   initial begin
      sb_t e;
      // lookup PC, upd {v, pc, taken, target, pred_taken, pred_target}, expected lookup, expected regs
      vecs.push_back(mk(32'h40, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h44,  1'b0, 0, 0));
      vecs.push_back(mk(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44,  1'b0, 1'b0, 32'h44,  1'b1, 1, 1));
      vecs.push_back(mk(32'h40, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 1, 1));
      vecs.push_back(mk(32'h40, 1'b1, 32'h40, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 2, 2));
      vecs.push_back(mk(32'h40, 1'b1, 32'h40, 1'b0, 32'h0,   1'b0, 32'h44,  1'b1, 1'b0, 32'h44,  1'b0, 3, 2));
      vecs.push_back(mk(32'h40, 1'b1, 32'h40, 1'b0, 32'h0,   1'b0, 32'h44,  1'b1, 1'b0, 32'h44,  1'b0, 4, 2));
      vecs.push_back(mk(32'h40, 1'b1, 32'h40, 1'b0, 32'h0,   1'b0, 32'h44,  1'b1, 1'b0, 32'h44,  1'b0, 5, 2));
      vecs.push_back(mk(32'h40, 1'b1, 32'h40, 1'b0, 32'h0,   1'b0, 32'h44,  1'b1, 1'b0, 32'h44,  1'b0, 6, 2));
      vecs.push_back(mk(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44,  1'b1, 1'b0, 32'h44,  1'b1, 7, 3));
      vecs.push_back(mk(32'h40, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h44,  1'b0, 7, 3));
      vecs.push_back(mk(32'h40, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 32'h44,  1'b1, 1'b0, 32'h44,  1'b1, 8, 4));
      vecs.push_back(mk(32'h40, 1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200, 1'b0, 9, 4));
      vecs.push_back(mk(32'h40, 1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200, 1'b0, 10, 4));
      vecs.push_back(mk(32'h40, 1'b1, 32'h40, 1'b0, 32'h0,   1'b1, 32'h200, 1'b1, 1'b1, 32'h200, 1'b1, 11, 5));
      vecs.push_back(mk(32'h40, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 11, 5));
      vecs.push_back(mk(32'h40, 1'b1, 32'h40, 1'b1, 32'h300, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200, 1'b1, 12, 6));
      vecs.push_back(mk(32'h40, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h300, 1'b0, 12, 6));
      vecs.push_back(mk(32'h1000, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b0, 32'h1004, 1'b0, 1'b0, 32'h1004, 1'b0, 13, 6));
      vecs.push_back(mk(32'h1000, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h1004, 1'b0, 13, 6));
      vecs.push_back(mk(32'h40, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h300, 1'b0, 13, 6));
      vecs.push_back(mk(32'h80, 1'b1, 32'h80, 1'b1, 32'h500, 1'b0, 32'h84,  1'b0, 1'b0, 32'h84,  1'b1, 14, 7));
      vecs.push_back(mk(32'h40, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h44,  1'b0, 14, 7));
      vecs.push_back(mk(32'h80, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h500, 1'b0, 14, 7));
      vecs.push_back(mk(32'hFFFF_FFFC, 1'b1, 32'h44, 1'b1, 32'h800, 1'b0, 32'h48, 1'b0, 1'b0, 32'h0, 1'b1, 15, 8));
      vecs.push_back(mk(32'h46, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h800, 1'b0, 15, 8));
      vecs.push_back(mk(32'h80, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h500, 1'b0, 15, 8));
      vecs.push_back(mk(32'h80, 1'b0, 32'h80, 1'b0, 32'h0,   1'b1, 32'h500, 1'b1, 1'b1, 32'h500, 1'b0, 15, 8));
      vecs.push_back(mk(32'h80, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h500, 1'b0, 15, 8));

      Reset = 1'b1;
      drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      repeat (2) @(negedge Clk);
      Reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge Clk);
         drive(vecs[i].lk_pc, vecs[i].upd_v, vecs[i].upd_pc, vecs[i].upd_tk,
               vecs[i].upd_tgt, vecs[i].upd_ptk, vecs[i].upd_ptgt);
         #1;
         check_lookup($sformatf("vec%0d", i), vecs[i].exp_hit, vecs[i].exp_tk, vecs[i].exp_npc);
         sb_q.push_back('{vecs[i].exp_mis, vecs[i].exp_bc, vecs[i].exp_mc});
         @(posedge Clk);
         #1;
         if (sb_q.size() == 0) begin
            chk($sformatf("vec%0d_sb_empty", i), 32'd0, 32'd1);
         end else begin
            e = sb_q.pop_front();
            check_regs($sformatf("vec%0d", i), e);
         end
      end

      // Allocate 0x100, then raise Reset mid-cycle while another update is pending.
      @(negedge Clk);
      drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h900, 1'b0, 32'h104);
      @(posedge Clk);
      #1;
      check_regs("alloc100", '{1'b1, 16, 9});
      @(negedge Clk);
      drive(32'h100, 1'b1, 32'h140, 1'b1, 32'hA00, 1'b0, 32'h144);
      #1;
      check_lookup("pre_rst", 1'b1, 1'b1, 32'h900);
      #1;
      Reset = 1'b1;
      #1;
      check_lookup("in_rst", 1'b0, 1'b0, 32'h104);
      check_regs("in_rst", '{1'b0, 0, 0});
      @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      drive(32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      check_lookup("post_rst140", 1'b0, 1'b0, 32'h144);
      LookupPC = 32'h44;
      #1;
      check_lookup("post_rst44", 1'b0, 1'b0, 32'h48);

      // Four correctly-predicted not-taken updates: narrow counter saturates at 3.
      for (int k = 0; k < 4; k++) begin
         @(negedge Clk);
         drive(32'h200, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h204);
         @(posedge Clk);
         #1;
      end
      @(negedge Clk);
      drive(32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      check_lookup("nt_miss", 1'b0, 1'b0, 32'h204);
      check_regs("sat4", '{1'b0, 4, 0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters, for the 5-stage pipeline.
- The fetch stage looks it up combinationally with the current PC and gets a predicted next PC in the same cycle.
- The decode stage, where branches resolve via the comparator, writes back the real outcome.
- Generalises the fixed PC+4/branch-mux next-PC selection into a configurable-depth, configurable-counter-width predictor with hit, mispredict and statistics tracking.

Parameters:
- ADDR_WIDTH, 32, PC width in bits.
- ENTRIES, 16, number of BTB entries; power of two, 2..1024.
- CTR_BITS, 2, saturating counter width; 1..4.
- STAT_WIDTH, 16, width of the saturating statistics counters.

Ports:
- Clk, input, 1, system clock; all state changes on the rising edge.
- Reset, input, 1, asynchronous active-high reset.
- LookupPC, input, ADDR_WIDTH, fetch-stage PC (PCResult).
- PredHit, output, 1, valid entry whose tag matches LookupPC.
- PredTaken, output, 1, PredHit AND counter MSB is 1.
- PredNextPC, output, ADDR_WIDTH, stored target if PredTaken, else LookupPC+4.
- UpdValid, input, 1, decode stage holds a resolved conditional branch this cycle.
- UpdPC, input, ADDR_WIDTH, PC of the resolved branch.
- UpdTaken, input, 1, actual outcome.
- UpdTarget, input, ADDR_WIDTH, actual taken target.
- UpdPredTaken, input, 1, prediction that was used for this branch (carried down the pipe).
- UpdPredTarget, input, ADDR_WIDTH, predicted next PC that was used.
- Mispredict, output, 1, registered; 1 for the cycle after an update whose prediction was wrong.
- BranchCount, output, STAT_WIDTH, saturating count of updates.
- MispredictCount, output, STAT_WIDTH, saturating count of mispredicts.

Behaviour:
- Indexing:
  - IDX = log2(ENTRIES).
  - index = PC[IDX+1:2]; tag = PC[ADDR_WIDTH-1:IDX+2].
  - PC[1:0] is ignored.
- Reset (async, immediate):
  - All valid bits 0; all counters set to weakly-not-taken (MSB 0, remaining bits 1; for CTR_BITS=1, value 0).
  - Mispredict 0, BranchCount 0, MispredictCount 0.
  - Lookup outputs then read miss: PredHit 0, PredTaken 0, PredNextPC = LookupPC+4.
  - Reset mid-update discards the update.
- Lookup:
  - Purely combinational, zero latency.
  - Reads the array state as of before the current edge.
  - A same-cycle update to the same index is not visible until the next cycle (read-before-write).
  - The +4 wraps modulo 2^ADDR_WIDTH.
- Update, on the rising edge when UpdValid=1:
  - Hit (valid and tag match):
    - UpdTaken=1: counter increments, saturating at all-ones.
    - UpdTaken=0: counter decrements, saturating at 0.
    - If UpdTaken=1, target is overwritten with UpdTarget.
  - Miss with UpdTaken=1: the entry is allocated and overwrites any previous occupant. Set valid=1, tag, target=UpdTarget, counter = weakly-taken (MSB 1, others 0).
  - Miss with UpdTaken=0: no allocation; array unchanged.
  - UpdValid=0: array and stats unchanged; Mispredict goes to 0 on the next edge.
- Mispredict:
  - Condition: (UpdPredTaken != UpdTaken) OR (UpdTaken AND UpdPredTarget != UpdTarget).
  - Registered: asserts for exactly one cycle after the update edge, and only when UpdValid=1.
- Statistics:
  - BranchCount increments on every valid update.
  - MispredictCount increments when the mispredict condition is true.
  - Both saturate at 2^STAT_WIDTH-1; neither wraps.
- Aliasing: two PCs with the same index and different tags evict each other. There is no associativity.
- No stall input. The pipeline gates UpdValid itself during stalls and flushes, so a branch is updated exactly once.

Test Plan:
1. Reset, then LookupPC=0x40 -> PredHit=0, PredTaken=0, PredNextPC=0x44; BranchCount=0.
2. Update {UpdPC=0x40, UpdTaken=1, UpdTarget=0x100, UpdPredTaken=0} -> next cycle Mispredict=1, MispredictCount=1; lookup 0x40 gives PredHit=1, PredTaken=1, PredNextPC=0x100.
3. Four not-taken updates at 0x40 (CTR_BITS=2) -> counter reaches 0 and stays there; PredTaken=0 after the first update, PredNextPC=0x44; the fifth update leaves the counter at 0.
4. Update at 0x40 and lookup 0x40 in the same cycle -> lookup shows pre-update values that cycle and updated values the next.
5. With ENTRIES=16, allocate 0x40 taken, then 0x80 taken (same index 0) -> lookup 0x40 gives PredHit=0, PredNextPC=0x44.
6. Assert Reset asynchronously mid-cycle with UpdValid=1 -> all outputs clear immediately, no entry allocated; with STAT_WIDTH=2, four valid updates leave BranchCount=3.
